// File: rtl/ws2811_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ws2811_pkg
//  Purpose : Shared definitions for the WS2811/WS2812 serial LED driver:
//            the ns-to-cycles rounding helper, nominal link timings, the
//            driver state encoding and the per-LED bit count.
//  Ports   : (package - none)
//  Rev     : 1.0  initial release
// ============================================================================
package ws2811_pkg;

    // Nominal link timings in nanoseconds (800 kHz NRZ)
    localparam longint T_BIT_NS   = 64'sd1250;
    localparam longint T0H_NS     = 64'sd350;
    localparam longint T1H_NS     = 64'sd700;
    localparam longint T_LATCH_NS = 64'sd60000;

    localparam int BITS_PER_LED   = 24;
    localparam int CLK_HZ_DEFAULT = 100_000_000;

    typedef enum logic {
        ST_LATCH = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    // Convert a duration in ns to clock cycles, rounded to nearest
    function automatic int cycles(input longint ns, input longint clk_hz);
        return int'((ns * clk_hz + 64'sd500_000_000) / 64'sd1_000_000_000);
    endfunction

    // Cycle counts at the default 100 MHz clock
    localparam int T_BIT   = cycles(T_BIT_NS,   64'(CLK_HZ_DEFAULT));
    localparam int T0H     = cycles(T0H_NS,     64'(CLK_HZ_DEFAULT));
    localparam int T1H     = cycles(T1H_NS,     64'(CLK_HZ_DEFAULT));
    localparam int T_LATCH = cycles(T_LATCH_NS, 64'(CLK_HZ_DEFAULT));

endpackage : ws2811_pkg
`default_nettype wire

// File: rtl/ws2811_bit_encoder.sv
`default_nettype none
// ============================================================================
//  Module  : ws2811_bit_encoder
//  Purpose : Turns one data bit into a pulse-width coded bit period.
//            A start pulse latches i_bit and begins a BIT_CYCLES-long period;
//            o_do is high for T1H_CYCLES (bit=1) or T0H_CYCLES (bit=0) from
//            the start edge. o_done flags the last cycle of the period so a
//            new start on that edge gives back-to-back bits with no gap.
//  Ports   : clk     in  system clock
//            reset   in  asynchronous active-low reset
//            i_start in  begin a new bit period on this edge
//            i_bit   in  bit value, sampled with i_start
//            o_do    out registered serial waveform
//            o_done  out high during the final cycle of a bit period
//  Rev     : 1.0  initial release
// ============================================================================
module ws2811_bit_encoder #(
    parameter int BIT_CYCLES = 125,
    parameter int T0H_CYCLES = 35,
    parameter int T1H_CYCLES = 70
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_bit,
    output logic o_do,
    output logic o_done
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] c_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] c_T0H  = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] c_T1H  = CW'(T1H_CYCLES);

    logic          r_busy;
    logic          r_bit;
    logic [CW-1:0] r_cnt;
    logic          r_do;

    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_high;
    logic          w_done;

    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_high    = r_bit ? c_T1H : c_T0H;
    assign w_done    = r_busy && (r_cnt == c_LAST);

    // DO is registered: it reflects (count < high time) for the count the
    // cycle will hold, so the line is high from the start edge onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_bit  <= 1'b0;
            r_cnt  <= '0;
            r_do   <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_bit  <= i_bit;
            r_cnt  <= '0;
            r_do   <= 1'b1;
        end else if (w_done) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_do   <= 1'b0;
        end else if (r_busy) begin
            r_cnt  <= w_cnt_nxt;
            r_do   <= (w_cnt_nxt < w_high);
        end
    end

    assign o_do   = r_do;
    assign o_done = w_done;

endmodule : ws2811_bit_encoder
`default_nettype wire

// File: rtl/ws2811_driver.sv
`default_nettype none
// ============================================================================
//  Module  : ws2811_driver
//  Purpose : Continuously refreshes a chain of NUM_LEDS WS2811/WS2812 LEDs.
//            A latch gap (DO low) is followed by NUM_LEDS x 24 GRB bits, MSB
//            first. The colour of each LED is fetched from an external store
//            through `address`, sampled only on that LED's load edge.
//  Ports   : clk       in  system clock, rising edge
//            reset     in  asynchronous active-low reset
//            address   out index of the LED to be loaded next
//            red_in    in  red for LED `address`
//            green_in  in  green for LED `address`
//            blue_in   in  blue for LED `address`
//            DO        out serial data to the first LED
//  Rev     : 1.0  initial release
// ============================================================================
module ws2811_driver
    import ws2811_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CLK_HZ   = 100_000_000,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] address,
    input  logic [7:0]    red_in,
    input  logic [7:0]    green_in,
    input  logic [7:0]    blue_in,
    output logic          DO
);

    localparam int c_T_BIT   = cycles(T_BIT_NS,   64'(CLK_HZ));
    localparam int c_T0H     = cycles(T0H_NS,     64'(CLK_HZ));
    localparam int c_T1H     = cycles(T1H_NS,     64'(CLK_HZ));
    localparam int c_T_LATCH = cycles(T_LATCH_NS, 64'(CLK_HZ));

    localparam int LW = $clog2(c_T_LATCH);
    localparam logic [LW-1:0] c_LATCH_LAST = LW'(c_T_LATCH - 1);
    localparam logic [AW-1:0] c_LAST_LED   = AW'(NUM_LEDS - 1);
    localparam logic [4:0]    c_FIRST_BIT  = 5'(BITS_PER_LED - 1);

    state_t        r_state;
    logic [LW-1:0] r_latch_cnt;
    logic [AW-1:0] r_led;
    logic [4:0]    r_bit_idx;
    logic [23:0]   r_shift;
    logic [AW-1:0] r_addr;

    logic [23:0]   w_pixel;
    logic          w_latch_done;
    logic          w_bit_done;
    logic          w_last_bit;
    logic          w_start;
    logic          w_start_bit;

    assign w_pixel      = {green_in, red_in, blue_in};
    assign w_latch_done = (r_state == ST_LATCH) && (r_latch_cnt == c_LATCH_LAST);
    assign w_last_bit   = (r_bit_idx == 5'd0) && (r_led == c_LAST_LED);

    // A new bit period begins on every load edge and on every bit end
    // except the final bit of the frame.
    assign w_start = w_latch_done ||
                     ((r_state == ST_SEND) && w_bit_done && !w_last_bit);

    // On a load edge the first bit comes straight from the inputs (green MSB);
    // otherwise it is the next bit waiting behind the current MSB.
    assign w_start_bit = (r_state == ST_LATCH || r_bit_idx == 5'd0) ?
                         green_in[7] : r_shift[22];

    ws2811_bit_encoder #(
        .BIT_CYCLES (c_T_BIT),
        .T0H_CYCLES (c_T0H),
        .T1H_CYCLES (c_T1H)
    ) u_enc (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_bit   (w_start_bit),
        .o_do    (DO),
        .o_done  (w_bit_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_LATCH;
            r_latch_cnt <= '0;
            r_led       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    if (w_latch_done) begin
                        r_state     <= ST_SEND;
                        r_latch_cnt <= '0;
                        r_led       <= '0;
                        r_bit_idx   <= c_FIRST_BIT;
                        r_shift     <= w_pixel;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + LW'(1);
                    end
                end
                ST_SEND: begin
                    if (w_bit_done) begin
                        if (r_bit_idx != 5'd0) begin
                            r_shift   <= r_shift << 1;
                            r_bit_idx <= r_bit_idx - 5'd1;
                            // Present the next LED's index a full bit period
                            // before its load edge so the store can respond.
                            if (r_bit_idx == 5'd1 && r_led != c_LAST_LED)
                                r_addr <= r_led + AW'(1);
                        end else if (r_led != c_LAST_LED) begin
                            r_shift   <= w_pixel;
                            r_led     <= r_led + AW'(1);
                            r_bit_idx <= c_FIRST_BIT;
                        end else begin
                            r_state <= ST_LATCH;
                            r_addr  <= '0;
                        end
                    end
                end
                default: r_state <= ST_LATCH;
            endcase
        end
    end

    assign address = r_addr;

endmodule : ws2811_driver
`default_nettype wire

// File: tb/tb_ws2811_driver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ws2811_driver
//  Purpose : Self-checking bench for ws2811_driver (NUM_LEDS=8, 100 MHz).
//            A colour store derived from `address` feeds the DUT; expected
//            24-bit GRB words are queued as stimulus is set up and a DO
//            decoder pops and compares them as LED words arrive.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ws2811_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] address;
    logic [7:0] red_in, green_in, blue_in;
    logic       DO;

    int     mode = 0;
    longint cyc  = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     words_done = 0;
    bit     mon_en = 1'b0;
    logic [23:0] exp_q[$];

    // decoder state
    logic        prev_do = 1'b0;
    bit          have_rise = 1'b0;
    longint      last_rise = 0;
    longint      hw = 0;
    int          nbits = 0;
    logic [23:0] word = '0;
    logic [23:0] ew;
    logic        bitv;

    ws2811_driver #(.NUM_LEDS(8), .CLK_HZ(100_000_000)) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .red_in   (red_in),
        .green_in (green_in),
        .blue_in  (blue_in),
        .DO       (DO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Colour store contents: {green, red, blue} for LED k under a given mode
    function automatic logic [23:0] grb(input int m, input int k);
        logic [7:0] r, g, b, kk;
        kk = k[7:0];
        case (m)
            0:       begin r = 8'hFF; g = 8'hAA;        b = 8'h00;        end
            1:       begin r = kk;    g = 8'h0F ^ kk;   b = 8'h80 | kk;   end
            default: begin r = kk;    g = 8'hC3;        b = 8'h3C + kk;   end
        endcase
        return {g, r, b};
    endfunction

    always_comb {green_in, red_in, blue_in} = grb(mode, int'(address));

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    // Counts clock edges from reset release up to the edge that raises DO
    task automatic measure_latch(output int n, output bit addr_bad);
        n = 0;
        addr_bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (DO !== 1'b1 && address !== 3'd0) addr_bad = 1'b1;
        end while (DO !== 1'b1 && n < 7000);
    endtask

    // DO decoder / scoreboard consumer
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_do   = 1'b0;
            have_rise = 1'b0;
            nbits     = 0;
            word      = '0;
        end else begin
            if (DO === 1'b1 && !prev_do) begin
                if (have_rise && (cyc - last_rise) < 1000)
                    check("bit_period", cyc - last_rise, 125);
                last_rise = cyc;
                have_rise = 1'b1;
            end else if (DO === 1'b0 && prev_do) begin
                hw   = cyc - last_rise;
                bitv = (hw > 52);
                check("high_width", hw, bitv ? 70 : 35);
                word = {word[22:0], bitv};
                nbits++;
                if (nbits == 24) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_depth", exp_q.size(), 1);
                    end else begin
                        ew = exp_q.pop_front();
                        check("led_word", word, ew);
                    end
                    words_done++;
                    nbits = 0;
                end
            end
            prev_do = (DO === 1'b1);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n;
        bit     addr_bad;
        longint ce;

        // Reset state
        reset = 1'b0;
        mode  = 0;
        repeat (5) @(negedge clk);
        check("rst_DO", longint'(DO), 0);
        check("rst_address", longint'(address), 0);

        // Frame 1: red=FF green=AA blue=00 for every LED
        for (int k = 0; k < 8; k++) exp_q.push_back(grb(0, k));
        mon_en = 1'b1;
        reset  = 1'b1;
        measure_latch(n, addr_bad);
        check("latch_len", n, 6000);
        check("latch_addr_zero", longint'(addr_bad), 0);
        ce = cyc;

        // Address walk: k appears at start of LED k-1's bit 0
        for (int k = 1; k < 8; k++) begin
            wait_cyc(ce + 2875 + (k - 1) * 3000 - 1);
            check("addr_before", longint'(address), k - 1);
            wait_cyc(ce + 2875 + (k - 1) * 3000);
            check("addr_after", longint'(address), k);
        end
        wait_cyc(ce + 23999);
        check("addr_last", longint'(address), 7);
        wait_cyc(ce + 24000);
        check("addr_wrap", longint'(address), 0);

        // Frame 2 uses red=address; colours switch mid-LED 3 (takes effect
        // from LED 4). Frame 3 stays on the new colours.
        wait_cyc(ce + 25000);
        mode = 1;
        for (int k = 0; k < 8; k++) exp_q.push_back(grb(k < 4 ? 1 : 2, k));
        for (int k = 0; k < 3; k++) exp_q.push_back(grb(2, k));

        // Frame period
        wait_cyc(ce + 29999);
        check("frame_gap_DO", longint'(DO), 0);
        wait_cyc(ce + 30000);
        check("frame2_first_high", longint'(DO), 1);
        check("frame2_addr", longint'(address), 0);

        wait_cyc(ce + 30000 + 9000 + 1500);
        mode = 2;

        // Reset mid-bit of LED 3 in frame 3
        wait_cyc(ce + 60000 + 9000 + 1030);
        check("pre_reset_DO", longint'(DO), 1);
        check("pre_reset_addr", longint'(address), 3);
        check("frames_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("reset_DO_now", longint'(DO), 0);
        check("reset_addr_now", longint'(address), 0);
        repeat (3) @(negedge clk);
        check("reset_DO_held", longint'(DO), 0);

        // Restart: full latch then LED 0 resent
        exp_q.push_back(grb(2, 0));
        mon_en = 1'b1;
        reset  = 1'b1;
        measure_latch(n, addr_bad);
        check("relatch_len", n, 6000);
        check("relatch_addr_zero", longint'(addr_bad), 0);
        ce = cyc;
        while (exp_q.size() != 0 && cyc < ce + 3200) @(negedge clk);
        check("restart_word_seen", exp_q.size(), 0);
        check("words_total", words_done, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ws2811_driver
`default_nettype wire
